od_buf_array_sync: RTL and testbench

//  Parametrised N-channel open-drain buffer for chip-level models. Each channel pulls
//  its output low or releases it (high-Z), with cycle-accurate propagation delay,
//  an optional per-channel input deglitch filter and a per-channel inverting option
//  (06-style vs 07-style). A saturating counter records rejected input glitches.

---
 rtl/od_buf_array_sync.sv | 115 +++++++++++
 tb/tb_od_buf_array_sync.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/od_buf_array_sync.sv
// N-channel open-drain buffer: request sampling, optional per-channel deglitch filter,
// fixed pipeline delay to the pull-low enable, and a saturating rejected-glitch counter.
module od_buf_array_sync #(
  parameter int unsigned         CHANNELS = 6,
  parameter int unsigned         DELAY    = 2,
  parameter int unsigned         FILTER   = 0,
  parameter logic [CHANNELS-1:0] INV_MASK = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vcc,
  input  logic                gnd,
  input  logic [CHANNELS-1:0] a,
  output wire  [CHANNELS-1:0] y,
  output logic [CHANNELS-1:0] drv,
  input  logic                glitch_clr,
  output logic [7:0]          glitch_cnt
);

  localparam int unsigned GW = 8;
  localparam int unsigned EW = $clog2(CHANNELS + 1);
  localparam int unsigned SW = ((EW > GW) ? EW : GW) + 1;
  localparam logic [GW-1:0] GMAX = '1;

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] f;
  logic [CHANNELS-1:0] ev;
  logic [EW-1:0]       ev_num;
  logic [SW-1:0]       sum;
  logic [GW-1:0]       cnt_nxt;

  // Power pins carry no logic.
  logic unused_pwr;
  assign unused_pwr = vcc ^ gnd;

  // 1 = pull low; inverting channels pull low on a high input.
  assign req = ~(a ^ INV_MASK);

  always_ff @(posedge clk) begin
    if (rst) s <= '0;
    else     s <= req;
  end

  if (FILTER == 0) begin : g_nofilt
    always_ff @(posedge clk) begin
      if (rst) f <= '0;
      else     f <= s;
    end
    assign ev = '0;
  end else begin : g_filt
    localparam int unsigned CW = $clog2(FILTER + 1);
    localparam logic [CW-1:0] CMAX = CW'(FILTER);
    logic [CW-1:0] c [CHANNELS];

    // A new level is accepted only after FILTER+1 consecutive differing samples.
    always_ff @(posedge clk) begin
      if (rst) begin
        f <= '0;
        for (int i = 0; i < int'(CHANNELS); i++) c[i] <= '0;
      end else begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
          if (s[i] == f[i]) begin
            c[i] <= '0;
          end else if (c[i] == CMAX) begin
            f[i] <= s[i];
            c[i] <= '0;
          end else begin
            c[i] <= c[i] + CW'(1);
          end
        end
      end
    end

    // An aborted run (input fell back before acceptance) is a rejected glitch.
    always_comb begin
      ev = '0;
      for (int i = 0; i < int'(CHANNELS); i++) ev[i] = (c[i] != '0) && (s[i] == f[i]);
    end
  end

  if (DELAY == 1) begin : g_nopipe
    assign drv = f;
  end else begin : g_pipe
    logic [CHANNELS-1:0] p [DELAY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < int'(DELAY) - 1; k++) p[k] <= '0;
      end else begin
        p[0] <= f;
        for (int k = 1; k < int'(DELAY) - 1; k++) p[k] <= p[k-1];
      end
    end
    assign drv = p[DELAY-2];
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_od
    assign y[i] = drv[i] ? 1'b0 : 1'bz;
  end

  always_comb begin
    ev_num = '0;
    for (int i = 0; i < int'(CHANNELS); i++) ev_num = ev_num + EW'(ev[i]);
    sum     = SW'(glitch_cnt) + SW'(ev_num);
    cnt_nxt = (sum > SW'(GMAX)) ? GMAX : sum[GW-1:0];
  end

  // Clear wins over events on the same edge.
  always_ff @(posedge clk) begin
    if (rst || glitch_clr) glitch_cnt <= '0;
    else                   glitch_cnt <= cnt_nxt;
  end

endmodule

// File: tb/tb_od_buf_array_sync.sv
// Bench for od_buf_array_sync: three parameterisations driven from shared inputs,
// each checked every cycle against a run-length/queue reference model.
module tb_od_buf_array_sync;

  logic       clk;
  logic       rst;
  logic       vcc;
  logic       gnd;
  logic       glitch_clr;
  logic [5:0] a;

  wire  [5:0] y0, y1, y2;
  logic [5:0] drv0, drv1, drv2;
  logic [7:0] gc0, gc1, gc2;

  // External pull-ups on the wired-AND nets.
  pullup pu0 (y0);
  pullup pu1 (y1);
  pullup pu2 (y2);

  od_buf_array_sync u_def (
    .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a), .y(y0), .drv(drv0),
    .glitch_clr(glitch_clr), .glitch_cnt(gc0)
  );

  od_buf_array_sync #(.CHANNELS(6), .DELAY(3), .FILTER(3), .INV_MASK(6'b000010)) u_flt (
    .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a), .y(y1), .drv(drv1),
    .glitch_clr(glitch_clr), .glitch_cnt(gc1)
  );

  od_buf_array_sync #(.CHANNELS(6), .DELAY(1), .FILTER(0), .INV_MASK(6'b000010)) u_inv (
    .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a), .y(y2), .drv(drv2),
    .glitch_clr(glitch_clr), .glitch_cnt(gc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic int p_flt(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic int p_dly(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction

  function automatic logic [5:0] p_inv(input int d);
    return (d == 0) ? 6'b000000 : 6'b000010;
  endfunction

  // Reference state: last sampled request, accepted level, length of the current
  // differing run, history of accepted levels (index 0 = newest), glitch total.
  logic [5:0] m_s   [3];
  logic [5:0] m_acc [3];
  int         m_run [3][6];
  logic [5:0] m_hist[3][4];
  int         m_cnt [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int d);
    logic [5:0] inv;
    logic [5:0] req;
    int         ev;
    inv = p_inv(d);
    ev  = 0;
    for (int i = 0; i < 6; i++) req[i] = inv[i] ? a[i] : !a[i];
    if (rst) begin
      m_s[d]   = '0;
      m_acc[d] = '0;
      for (int i = 0; i < 6; i++) m_run[d][i] = 0;
      for (int k = 0; k < 4; k++) m_hist[d][k] = '0;
      m_cnt[d] = 0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (p_flt(d) == 0) begin
          m_acc[d][i] = m_s[d][i];
        end else if (m_s[d][i] == m_acc[d][i]) begin
          if (m_run[d][i] > 0) ev++;
          m_run[d][i] = 0;
        end else begin
          m_run[d][i]++;
          if (m_run[d][i] > p_flt(d)) begin
            m_acc[d][i] = m_s[d][i];
            m_run[d][i] = 0;
          end
        end
      end
      for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
      m_hist[d][0] = m_acc[d];
      m_s[d] = req;
      if (glitch_clr) m_cnt[d] = 0;
      else            m_cnt[d] = (m_cnt[d] + ev > 255) ? 255 : m_cnt[d] + ev;
    end
  endtask

  // One clock edge: advance the model, then check every DUT output just after the edge.
  task automatic tick();
    logic [5:0] ed [3];
    logic [5:0] ey [3];
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      model_edge(d);
      ed[d] = m_hist[d][p_dly(d) - 1];
      ey[d] = ~ed[d];
    end
    #1;
    check("drv_def", 32'(drv0), 32'(ed[0]));
    check("y_def",   32'(y0),   32'(ey[0]));
    check("cnt_def", 32'(gc0),  32'(m_cnt[0]));
    check("drv_flt", 32'(drv1), 32'(ed[1]));
    check("y_flt",   32'(y1),   32'(ey[1]));
    check("cnt_flt", 32'(gc1),  32'(m_cnt[1]));
    check("drv_inv", 32'(drv2), 32'(ed[2]));
    check("y_inv",   32'(y2),   32'(ey[2]));
    check("cnt_inv", 32'(gc2),  32'(m_cnt[2]));
  endtask

  initial begin
    vcc        = 1'b1;
    gnd        = 1'b0;
    rst        = 1'b1;
    glitch_clr = 1'b0;
    a          = 6'h3F;

    // Reset state with all inputs high.
    tick();
    check("rst_y_def", 32'(y0), 32'h3F);
    check("rst_drv_def", 32'(drv0), 32'h0);
    check("rst_cnt_def", 32'(gc0), 32'h0);
    rst = 1'b0;
    repeat (8) tick();

    // Non-inverting channel, DELAY=2, no filter: two-edge latency.
    a[0] = 1'b0;
    tick();
    check("lat_k0", 32'(drv0[0]), 32'h0);
    tick();
    check("lat_k1", 32'(y0[0]), 32'h1);
    tick();
    check("lat_k2_drv", 32'(drv0[0]), 32'h1);
    check("lat_k2_y", 32'(y0[0]), 32'h0);
    repeat (4) tick();
    a[0] = 1'b1;
    repeat (10) tick();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;

    // Filtered channel: 3-sample pulse rejected, 4-sample pulse accepted.
    a[2] = 1'b0;
    repeat (3) tick();
    a[2] = 1'b1;
    repeat (4) tick();
    check("flt_short_cnt", 32'(gc1), 32'h1);
    check("flt_short_y", 32'(y1[2]), 32'h1);
    a[2] = 1'b0;
    repeat (6) tick();
    check("flt_long_k5", 32'(drv1[2]), 32'h0);
    tick();
    check("flt_long_k6", 32'(y1[2]), 32'h0);
    a[2] = 1'b1;
    repeat (10) tick();

    // Inverting channel 1 on the DELAY=1 instance.
    a = 6'h00;
    repeat (4) tick();
    check("inv_lo", 32'(y2), 32'h02);
    a[1] = 1'b1;
    tick();
    check("inv_k0", 32'(y2[1]), 32'h1);
    tick();
    check("inv_k1", 32'(y2), 32'h00);

    // Reset while a low request is in flight, request held afterwards.
    a = 6'h3F;
    repeat (10) tick();
    a[0] = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_drv_def", 32'(drv0), 32'h0);
    check("mid_rst_drv_flt", 32'(drv1), 32'h0);
    check("mid_rst_drv_inv", 32'(drv2), 32'h0);
    check("mid_rst_y_def", 32'(y0), 32'h3F);
    rst = 1'b0;
    repeat (2) tick();
    check("post_rst_k2", 32'(drv0[0]), 32'h0);
    tick();
    check("post_rst_k3", 32'(y0[0]), 32'h0);
    a = 6'h3F;
    repeat (10) tick();

    // Saturation: 2-cycle pulses on channels 3 and 4; clear lands on the last glitch edge.
    for (int p = 0; p < 300; p++) begin
      a[3] = 1'b0;
      a[4] = 1'b0;
      repeat (2) tick();
      a[3] = 1'b1;
      a[4] = 1'b1;
      tick();
      if (p == 299) begin
        check("sat_cnt", 32'(gc1), 32'd255);
        glitch_clr = 1'b1;
      end
      tick();
      glitch_clr = 1'b0;
    end
    check("sat_clr", 32'(gc1), 32'h0);
    tick();
    check("sat_clr_hold", 32'(gc1), 32'h0);

    // Randomised phases with decreasing toggle density.
    for (int ph = 0; ph < 3; ph++) begin
      int den;
      den = 2 << ph;
      for (int n = 0; n < 600; n++) begin
        for (int i = 0; i < 6; i++)
          if ($urandom_range(den - 1, 0) == 0) a[i] = ~a[i];
        rst        = ($urandom_range(199, 0) == 0);
        glitch_clr = ($urandom_range(39, 0) == 0);
        tick();
      end
    end
    rst        = 1'b0;
    glitch_clr = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
